bpsk_symbol_sequencer: RTL
==========================

Name: bpsk_symbol_sequencer

Overview:
Controller that sequences the 30-entry carrier sine ROM for the BPSK modulator.
- Accepts data bits over a valid/ready handshake.
- For each bit, walks the ROM address through CYCLES_PER_BIT full carrier periods.
- Flags phase inversion for bit 0. The downstream sample path negates the ROM output when phase_inv is high.
- Sits between the bit source and the sine ROM / output mixer.

Parameters:
- TABLE_LEN, 30: samples per carrier period (ROM depth).
- ADDR_W, 5: ROM address width; 2^ADDR_W >= TABLE_LEN.
- CYCLES_PER_BIT, 4: carrier periods per symbol, >= 1.
- CNT_W, 16: width of symbol counter.

Ports:
- Clk, in, 1: system clock, rising edge.
- Rst_n, in, 1: synchronous active-low reset.
- enable, in, 1: run request; deassertion stops at the next symbol boundary.
- bit_in, in, 1: data bit.
- bit_valid, in, 1: bit_in valid.
- bit_ready, out, 1: sequencer accepts bit this cycle.
- underrun_clr, in, 1: clears underrun.
- rom_addr, out, ADDR_W: sine ROM address.
- phase_inv, out, 1: 1 = negate sample (current bit = 0).
- sample_valid, out, 1: rom_addr/phase_inv valid this cycle.
- sym_start, out, 1: pulse with first sample of each symbol.
- busy, out, 1: state is RUN.
- underrun, out, 1: sticky; bit stream starved while enabled.
- sym_count, out, CNT_W: symbols started, wraps.

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous, active-low on Rst_n. All state updates occur on the rising edge of Clk.
- Reset values: rom_addr=0, phase_inv=0, sample_valid=0, sym_start=0, busy=0, underrun=0, sym_count=0, state=IDLE, internal cycle counter=0.
- bit_ready is 0 while Rst_n=0.
- Accept: a bit is accepted when bit_valid & bit_ready. bit_ready is combinational from state/counters/enable, never from bit_valid.

States:
- IDLE:
  - bit_ready = enable.
  - On accept, next cycle: state=RUN, rom_addr=0, cycle counter=0, phase_inv=~bit_in, sample_valid=1, sym_start=1, sym_count+1.
  - Otherwise all outputs hold, with sample_valid=0 and sym_start=0.
- RUN:
  - sample_valid=1 every cycle. sym_start=0 except on a symbol's first sample.
  - rom_addr increments by 1 per cycle. At TABLE_LEN-1 it wraps to 0 and the cycle counter increments.
  - Last sample of symbol: rom_addr==TABLE_LEN-1 and cycle counter==CYCLES_PER_BIT-1.
  - bit_ready = enable only on the last-sample cycle, else 0.
- Symbol boundary (last-sample cycle):
  - Accept: seamless next symbol. Next cycle rom_addr=0, cycle counter=0, phase_inv=~bit_in, sym_start=1, sym_count+1. No gap cycle.
  - No accept, enable=1: underrun<=1, go IDLE.
  - No accept, enable=0: go IDLE without setting underrun.
  - On entering IDLE: sample_valid=0, rom_addr=0, phase_inv=0.
- Latency and symbol length:
  - Accept at cycle t gives the first sample at t+1.
  - Symbol length is exactly TABLE_LEN*CYCLES_PER_BIT sample cycles.
- phase_inv is constant for the entire symbol. A change in bit value takes effect only at rom_addr=0, so phase flips occur at carrier zero crossings.
- enable falling mid-symbol does not truncate the symbol. It blocks acceptance at the boundary.
- bit_valid/bit_in changes while bit_ready=0 are ignored. No internal buffering; exactly one bit is in flight.
- underrun:
  - Set on the starved boundary.
  - Cleared by underrun_clr in the following cycle.
  - If set and clear occur in the same cycle, set wins.
- sym_count wraps from 2^CNT_W-1 to 0.
- Reset mid-symbol: outputs return to reset values next cycle, and the in-flight bit is discarded.

Test Plan:
Bench parameters: TABLE_LEN=30, CYCLES_PER_BIT=2, so 60 samples per symbol.
1. Reset, then enable=1 with bit_valid=1, bit_in=1 held -> bit_ready=1 at the IDLE cycle. Next cycle: rom_addr=0, sym_start=1, phase_inv=0, sym_count=1. rom_addr sequences 0..29,0..29. bit_ready pulses at sample 60. Second symbol starts with no gap, sym_count=2.
2. Bits 1,0,1 streamed back-to-back -> phase_inv is 0 for samples 1-60, 1 for 61-120, 0 for 121-180. Every toggle coincides with rom_addr=0 and sym_start=1.
3. One bit, then bit_valid=0 with enable=1 -> at the end of sample 60: state IDLE, sample_valid=0, underrun=1. underrun_clr pulse -> underrun=0.
4. enable dropped at sample 10 of a symbol with bit_valid=1 -> the symbol completes all 60 samples, bit_ready stays 0, IDLE follows, underrun stays 0.
5. Rst_n=0 at sample 25 -> next cycle all outputs at reset values and bit_ready=0. After release, a new accept starts from rom_addr=0.
6. CNT_W=2 override with 5 consecutive symbols -> sym_count reads 1,2,3,0,1.

Source files
------------

// File: rtl/bpsk_symbol_sequencer.sv
// rtl/bpsk_symbol_sequencer.sv - BPSK carrier ROM address sequencer with per-bit phase inversion
module bpsk_symbol_sequencer #(
  parameter int TABLE_LEN      = 30,
  parameter int ADDR_W         = 5,
  parameter int CYCLES_PER_BIT = 4,
  parameter int CNT_W          = 16
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              enable,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic              bit_ready,
  input  logic              underrun_clr,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              phase_inv,
  output logic              sample_valid,
  output logic              sym_start,
  output logic              busy,
  output logic              underrun,
  output logic [CNT_W-1:0]  sym_count
);

  localparam int CYC_W = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(TABLE_LEN - 1);
  localparam logic [CYC_W-1:0]  CYC_LAST  = CYC_W'(CYCLES_PER_BIT - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state, state_n;
  logic [CYC_W-1:0]   cyc_cnt, cyc_cnt_n;
  logic [ADDR_W-1:0]  rom_addr_n;
  logic               phase_inv_n;
  logic               sample_valid_n;
  logic               sym_start_n;
  logic               underrun_n;
  logic               underrun_set;
  logic [CNT_W-1:0]   sym_count_n;
  logic               last_sample;
  logic               accept;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state        <= IDLE;
      cyc_cnt      <= '0;
      rom_addr     <= '0;
      phase_inv    <= 1'b0;
      sample_valid <= 1'b0;
      sym_start    <= 1'b0;
      underrun     <= 1'b0;
      sym_count    <= '0;
    end else begin
      state        <= state_n;
      cyc_cnt      <= cyc_cnt_n;
      rom_addr     <= rom_addr_n;
      phase_inv    <= phase_inv_n;
      sample_valid <= sample_valid_n;
      sym_start    <= sym_start_n;
      underrun     <= underrun_n;
      sym_count    <= sym_count_n;
    end
  end

  always_comb begin
    last_sample    = (state == RUN) && (rom_addr == ADDR_LAST) && (cyc_cnt == CYC_LAST);
    // Ready only in IDLE or on the final sample, so a new bit always starts at rom_addr 0.
    bit_ready      = Rst_n && enable && ((state == IDLE) || last_sample);
    accept         = bit_valid && bit_ready;

    state_n        = state;
    cyc_cnt_n      = cyc_cnt;
    rom_addr_n     = rom_addr;
    phase_inv_n    = phase_inv;
    sample_valid_n = 1'b0;
    sym_start_n    = 1'b0;
    sym_count_n    = sym_count;
    underrun_set   = 1'b0;

    if (accept) begin
      state_n        = RUN;
      cyc_cnt_n      = '0;
      rom_addr_n     = '0;
      phase_inv_n    = ~bit_in;
      sample_valid_n = 1'b1;
      sym_start_n    = 1'b1;
      sym_count_n    = sym_count + CNT_W'(1);
    end else if (state == RUN) begin
      if (last_sample) begin
        // Boundary with no new bit: starved only if the source was still asked to run.
        state_n      = IDLE;
        cyc_cnt_n    = '0;
        rom_addr_n   = '0;
        phase_inv_n  = 1'b0;
        underrun_set = enable;
      end else begin
        sample_valid_n = 1'b1;
        if (rom_addr == ADDR_LAST) begin
          rom_addr_n = '0;
          cyc_cnt_n  = cyc_cnt + CYC_W'(1);
        end else begin
          rom_addr_n = rom_addr + ADDR_W'(1);
        end
      end
    end

    underrun_n = underrun_set || (underrun && !underrun_clr);
  end

  assign busy = (state == RUN);

endmodule
